// File: rtl/biu_pkg.sv
// rtl/biu_pkg.sv - shared types and constants for the BIU arbiter
package biu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    localparam logic [1:0] BIU_MOV  = 2'b00;
    localparam logic [1:0] BIU_LDST = 2'b01;

    localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin pick: first set request at or above ptr, wrapping
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic             valid,
    output logic [PW-1:0]    winner,
    output logic [N_REQ-1:0] onehot
);

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            int idx;
            idx = int'(ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = PW'(idx);
            end
        end
        if (valid) begin
            onehot[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/biu_arbiter.sv
// rtl/biu_arbiter.sv - round-robin owner of the single BIU with ready watchdog
module biu_arbiter
    import biu_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] op,
    input  logic               ready_bus,
    output logic               cs_biu,
    output logic [1:0]         sel_biu,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic               timeout_err,
    output logic               busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int PW    = $clog2(N_REQ);

    state_e             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [1:0]         sel_q, sel_d;
    logic               cs_q, cs_d;
    logic               to_q, to_d;
    logic               busy_q, busy_d;

    logic               pick_valid;
    logic [PW-1:0]      pick_winner;
    logic [N_REQ-1:0]   pick_onehot;

    rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .winner (pick_winner),
        .onehot (pick_onehot)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        cs_d    = 1'b0;
        done_d  = '0;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                // The done cycle is dead time: the old owner gets one cycle to drop req.
                if (pick_valid && (done_q == '0)) begin
                    grant_d = pick_onehot;
                    sel_d   = op[{pick_winner, 1'b0} +: 2];
                    owner_d = pick_winner;
                    cs_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (ready_bus || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    done_d  = grant_q;
                    to_d    = !ready_bus;
                    grant_d = '0;
                    sel_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + PW'(1);
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            sel_q   <= '0;
            cs_q    <= 1'b0;
            to_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            sel_q   <= sel_d;
            cs_q    <= cs_d;
            to_q    <= to_d;
            busy_q  <= busy_d;
        end
    end

    assign cs_biu      = cs_q;
    assign sel_biu     = sel_q;
    assign grant       = grant_q;
    assign done        = done_q;
    assign timeout_err = to_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_biu_arbiter.sv
// tb/tb_biu_arbiter.sv - scoreboard bench for biu_arbiter with a transaction-level model
module tb_biu_arbiter;

    localparam int N  = 3;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [2*N-1:0] op = '0;
    logic           ready_bus = 1'b0;
    logic           cs_biu;
    logic [1:0]     sel_biu;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           timeout_err;
    logic           busy;

    biu_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .op          (op),
        .ready_bus   (ready_bus),
        .cs_biu      (cs_biu),
        .sel_biu     (sel_biu),
        .grant       (grant),
        .done        (done),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         w;
        logic [1:0] sel;
        int         lat;
        bit         to;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   mptr = 0;
    bit   mon_en = 1'b0;
    bit   active = 1'b0;
    int   ccnt = 0;
    int   last_cs = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) begin
            if (r[(mptr + i) % N]) return (mptr + i) % N;
        end
        return -1;
    endfunction

    task automatic wait_cs(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cs_biu && n < 8);
        if (!cs_biu) begin
            $display("FAIL %s: cs_biu never rose (got 0 expected 1)", name);
            errors++;
            $fatal(1, "bound expired");
        end
    endtask

    // One arbitrated transaction: ready arrives on WAIT edge k (k >= TO means never).
    task automatic drive_txn(input logic [N-1:0] r, input logic [2*N-1:0] o, input int k, input bit drop);
        exp_t e;
        int   w;
        @(negedge clk);
        req = r;
        op = o;
        ready_bus = 1'b0;
        w = model_pick(r);
        e.w = w;
        e.sel = o[2*w +: 2];
        e.to = (k > TO - 1);
        e.lat = 2 + ((k > TO - 1) ? TO - 1 : k);
        q.push_back(e);
        mptr = (w + 1) % N;
        wait_cs("txn_cs");
        ready_bus = 1'($urandom_range(0, 1));
        if (drop) begin
            req = '0;
            op = 6'($urandom);
        end
        for (int j = 0; j < TO; j++) begin
            @(negedge clk);
            ready_bus = (j == k);
            if (j == k || j == TO - 1) break;
        end
        @(negedge clk);
        ready_bus = 1'b0;
        req = '0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
                if (grant == '0) chk("sel_idle_zero", 32'(sel_biu), 32'd0);
                if (cs_biu) begin
                    if (q.size() == 0) begin
                        chk("unexpected_cs", 32'd1, 32'd0);
                    end else begin
                        cur = q.pop_front();
                        active = 1'b1;
                        ccnt = 0;
                        chk("grant_at_cs", 32'(grant), 32'(1 << cur.w));
                        chk("sel_at_cs", 32'(sel_biu), 32'(cur.sel));
                        chk("busy_at_cs", 32'(busy), 32'd1);
                        if (last_cs >= 0) chk("cs_spacing_ge4", 32'((cyc - last_cs) >= 4), 32'd1);
                        last_cs = cyc;
                    end
                end else if (active) begin
                    ccnt++;
                    if (done != '0) begin
                        chk("done_owner", 32'(done), 32'(1 << cur.w));
                        chk("timeout_err", 32'(timeout_err), 32'(cur.to));
                        chk("done_latency", 32'(ccnt), 32'(cur.lat));
                        chk("grant_after_done", 32'(grant), 32'd0);
                        chk("busy_after_done", 32'(busy), 32'd0);
                        active = 1'b0;
                    end else begin
                        chk("grant_hold", 32'(grant), 32'(1 << cur.w));
                        chk("to_quiet", 32'(timeout_err), 32'd0);
                        if (ccnt > TO + 4) begin
                            chk("done_never_came", 32'd0, 32'd1);
                            active = 1'b0;
                        end
                    end
                end else begin
                    chk("done_idle", 32'(done), 32'd0);
                    chk("to_idle", 32'(timeout_err), 32'd0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish (got hang expected finish)");
        $fatal(1, "time limit");
    end

    initial begin
        logic [N-1:0]   r;
        logic [2*N-1:0] o;
        int             k;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_cs", 32'(cs_biu), 32'd0);
        chk("rst_sel", 32'(sel_biu), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_to", 32'(timeout_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Reset in WAIT, then a fresh pick from ptr=0.
        rst_n = 1'b1;
        req = 3'b001;
        op = 6'b000001;
        wait_cs("rst_test_cs");
        chk("rst_test_grant", 32'(grant), 32'd1);
        repeat (3) @(negedge clk);
        chk("rst_test_busy_wait", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_cs", 32'(cs_biu), 32'd0);
        rst_n = 1'b1;
        req = 3'b010;
        op = 6'b000100;
        wait_cs("post_rst_cs");
        chk("post_rst_grant", 32'(grant), 32'b010);
        chk("post_rst_sel", 32'(sel_biu), 32'b01);
        @(negedge clk);
        ready_bus = 1'b1;
        @(negedge clk);
        ready_bus = 1'b0;
        req = '0;
        chk("post_rst_done", 32'(done), 32'b010);
        chk("post_rst_to", 32'(timeout_err), 32'd0);
        mptr = 2;
        mon_en = 1'b1;

        drive_txn(3'b001, 6'b000001, 2, 1'b0);
        repeat (4) drive_txn(3'b011, 6'($urandom), 0, 1'b0);
        drive_txn(3'b010, 6'($urandom), TO + 5, 1'b0);
        drive_txn(3'b100, 6'($urandom), TO - 1, 1'b0);
        drive_txn(3'b111, 6'($urandom), TO - 2, 1'b0);
        drive_txn(3'b101, 6'($urandom), 3, 1'b1);

        for (int t = 0; t < 60; t++) begin
            r = 3'($urandom_range(1, 7));
            o = 6'($urandom);
            if ($urandom_range(0, 3) == 0) k = $urandom_range(TO - 2, TO + 2);
            else k = $urandom_range(0, 5);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            drive_txn(r, o, k, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("no_txn_pending", 32'(active), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
